seg_display_scheduler: RTL and testbench
========================================

// Module: seg_display_scheduler
// PURPOSE
//   Time-multiplexes the four 8-bit seven-segment digit patterns produced by the heartbeat
//   pattern generator onto one shared 4-anode display. One digit slot at a time, with an
//   anti-ghosting blank interval per slot and 4-bit PWM brightness control. Inputs are
//   latched once per frame, so a pattern change never tears mid-frame.
// PARAMETERS
//   SLOT_CYCLES   50000  clk cycles per digit slot (frame = 4*SLOT_CYCLES); must be >= 2
//   BLANK_CYCLES  500    cycles at start of each slot with all anodes off; 1 <= BLANK_CYCLES < SLOT_CYCLES
// PORTS
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   dig_0..3    in   8  segment patterns {dp,g,f,e,d,c,b,a}, active-low, passed through unmodified
//   en_mask     in   4  bit i=1 enables digit i
//   duty        in   4  brightness: 0=off, 1..14 = duty/16 on-time, 15=always on
//   an          out  4  anode selects, active-low, one-hot-low or all-high
//   sseg        out  8  segment drive, active-low
//   frame_tick  out  1  one-cycle pulse when shadow registers load (frame start)
// BEHAVIOUR
//   - All outputs registered. Reset values: an=4'hF, sseg=8'hFF, frame_tick=0; internal
//     slot counter=0, digit index=0, PWM counter=0, shadow dig=8'hFF, shadow en=0, shadow duty=0.
//   - Reset mid-operation: all state returns to reset values on the next edge; no partial slot.
//   - Cycle numbering: c=0 is the first edge with reset low. Counters advance every cycle.
//   - Slot counter cnt runs 0..SLOT_CYCLES-1; on wrap, digit index increments 0->1->2->3->0.
//   - Frame boundary = internal cnt==0 && idx==0 (first at c=0). On that cycle dig_0..3,
//     en_mask, duty are copied into shadow registers; frame_tick is high for that cycle's
//     registered output (visible after edge c=0, low otherwise). Input changes at any other
//     time affect nothing until the next boundary.
//   - FSM per slot, two states: BLANK (cnt < BLANK_CYCLES) and DRIVE (cnt >= BLANK_CYCLES).
//     BLANK: an=4'hF, sseg=8'hFF.
//     DRIVE: if shadow_en[idx] && lit then an = ~(4'b1<<idx), sseg = shadow_dig[idx];
//            else an=4'hF, sseg=8'hFF.
//   - PWM: 4-bit pwm_cnt, free-running, wraps 15->0, not reset by slot changes.
//     lit = (duty==15) || (pwm_cnt < duty). duty=0 -> never lit.
//   - Disabled digit still consumes its full slot (frame period constant regardless of mask).
//   - Invariant: at most one an bit low at any cycle; an and sseg change on the same edge.
//   - Output latency: an/sseg reflect the counter state of the previous cycle (1 cycle).
// STRUCTURE
//   - Shared header seg_display_defs.vh: NUM_DIGITS=4, SEG_OFF=8'hFF, AN_OFF=4'hF,
//     ST_BLANK/ST_DRIVE encodings, DUTY_FULL=4'd15.
//   - Sub-module seg_slot_timer: cnt, idx, frame-boundary strobe, in_blank flag.
//   - Top: shadow registers, PWM counter, FSM/output mux, output registers.
// TESTING (SLOT_CYCLES=8, BLANK_CYCLES=2 unless noted)
//   1. Reset 3 cycles, release, dig=8'hC0/F9/A4/B0, en=4'hF, duty=15 -> frame_tick high
//      at c=0,32,64 only; an sequence per slot = F,F,E,E,E,E,E,E then F,F,D..., sseg=C0 during an=E.
//   2. en_mask=4'b0101 -> an never 4'hD or 4'h7; frame period still 32 cycles; an=F during slots 1,3.
//   3. duty=4 -> in DRIVE, an low exactly when pwm_cnt<4; over 256 cycles lit count = 1/4 of
//      DRIVE cycles +-1 PWM period per slot; duty=0 -> an=4'hF forever.
//   4. Change dig_0 8'hC0->8'h80 at c=10 -> sseg for digit 0 stays C0 until frame at c=32,
//      shows 80 from slot 0 of that frame.
//   5. Assert reset at c=13 for 1 cycle -> next edge an=F, sseg=FF, frame_tick=0; then
//      sequence restarts exactly as test 1 from new c=0.
//   6. Random dig/en/duty over 10k cycles -> assert an in {F,E,D,B,7} and one-hot-low every cycle.

Source files
------------

// File: rtl/seg_display_scheduler_pkg.sv
// rtl/seg_display_scheduler_pkg.sv - shared constants, state encoding and helpers for the display scheduler
package seg_display_scheduler_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam int          IDX_W      = 2;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'hF;
  localparam logic [3:0]  DUTY_FULL  = 4'd15;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

  // Full duty bypasses the comparator so the digit never drops out for one PWM step.
  function automatic logic pwm_lit(input logic [3:0] duty, input logic [3:0] pwm_cnt);
    return (duty == DUTY_FULL) || (pwm_cnt < duty);
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// rtl/seg_display_scheduler_if.sv - pattern inputs and display drive outputs of the scheduler
interface seg_display_scheduler_if;
  import seg_display_scheduler_pkg::*;

  logic [7:0]            dig_0;
  logic [7:0]            dig_1;
  logic [7:0]            dig_2;
  logic [7:0]            dig_3;
  logic [NUM_DIGITS-1:0] en_mask;
  logic [3:0]            duty;
  logic [NUM_DIGITS-1:0] an;
  logic [7:0]            sseg;
  logic                  frame_tick;

  modport master (
    output dig_0, dig_1, dig_2, dig_3, en_mask, duty,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  dig_0, dig_1, dig_2, dig_3, en_mask, duty,
    output an, sseg, frame_tick
  );

endinterface

// File: rtl/seg_display_scheduler_slot_timer.sv
// rtl/seg_display_scheduler_slot_timer.sv - per-slot cycle counter, digit index and frame/phase strobes
module seg_display_scheduler_slot_timer
  import seg_display_scheduler_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx,
  output logic             frame_start,
  output logic             blank_last,
  output logic             slot_last
);

  localparam int            CW         = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_END   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Digit index wraps naturally at NUM_DIGITS because it is exactly IDX_W bits wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == SLOT_END) begin
      cnt <= '0;
      idx <= idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign frame_start = (cnt == '0) && (idx == '0);
  assign blank_last  = (cnt == BLANK_END);
  assign slot_last   = (cnt == SLOT_END);

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - multiplexes four digit patterns onto one display with blanking and PWM
module seg_display_scheduler
  import seg_display_scheduler_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  seg_display_scheduler_if.slave  bus
);

  logic [IDX_W-1:0]      idx;
  logic                  frame_start;
  logic                  blank_last;
  logic                  slot_last;

  logic [7:0]            shadow_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_en;
  logic [3:0]            shadow_duty;
  logic [3:0]            pwm_cnt;
  logic                  drive_on;
  slot_state_t           state;

  seg_display_scheduler_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk         (clk),
    .reset       (reset),
    .idx         (idx),
    .frame_start (frame_start),
    .blank_last  (blank_last),
    .slot_last   (slot_last)
  );

  // Inputs are only sampled at the frame boundary so a pattern update never tears a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_dig[i] <= SEG_OFF;
      shadow_en   <= '0;
      shadow_duty <= '0;
    end else if (frame_start) begin
      shadow_dig[0] <= bus.dig_0;
      shadow_dig[1] <= bus.dig_1;
      shadow_dig[2] <= bus.dig_2;
      shadow_dig[3] <= bus.dig_3;
      shadow_en     <= bus.en_mask;
      shadow_duty   <= bus.duty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign drive_on = shadow_en[idx] && pwm_lit(shadow_duty, pwm_cnt);

  // State tracks the phase of the current slot count; outputs register one cycle behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_BLANK;
      bus.an         <= AN_OFF;
      bus.sseg       <= SEG_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= frame_start;
      case (state)
        ST_BLANK: begin
          bus.an   <= AN_OFF;
          bus.sseg <= SEG_OFF;
          if (blank_last) state <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (drive_on) begin
            bus.an   <= anode_sel(idx);
            bus.sseg <= shadow_dig[idx];
          end else begin
            bus.an   <= AN_OFF;
            bus.sseg <= SEG_OFF;
          end
          if (slot_last) state <= ST_BLANK;
        end
        default: begin
          state    <= ST_BLANK;
          bus.an   <= AN_OFF;
          bus.sseg <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - directed and random checks of the display scheduler
module tb_seg_display_scheduler;
  import seg_display_scheduler_pkg::*;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_display_scheduler_if bus();

  seg_display_scheduler #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_mis = 0;
  int         c = 0;
  int         lit_cnt = 0;
  int         bad_an = 0;
  logic [7:0] f_dig [4];
  logic [3:0] f_en;
  logic [3:0] f_duty;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (c=%0d)", tag, got, exp, c);
    end
  endtask

  // Expected outputs after edge c follow from c alone plus the inputs seen at the last frame start.
  task automatic step(input string tag);
    logic [3:0] e_an;
    logic [7:0] e_sseg;
    int         cnt;
    int         idx;
    int         pwm;
    logic       lit;
    if (c % FRAME == 0) begin
      f_dig[0] = bus.dig_0;
      f_dig[1] = bus.dig_1;
      f_dig[2] = bus.dig_2;
      f_dig[3] = bus.dig_3;
      f_en     = bus.en_mask;
      f_duty   = bus.duty;
    end
    cnt = c % SLOT;
    idx = (c / SLOT) % 4;
    pwm = c % 16;
    lit = (f_duty == 4'd15) || (pwm < int'(f_duty));
    if (cnt >= BLANK && f_en[idx] && lit) begin
      e_an   = ~(4'b0001 << idx);
      e_sseg = f_dig[idx];
    end else begin
      e_an   = 4'hF;
      e_sseg = 8'hFF;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".an"}, 32'(bus.an), 32'(e_an));
    check_eq({tag, ".sseg"}, 32'(bus.sseg), 32'(e_sseg));
    check_eq({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'(c % FRAME == 0));
    if (bus.an != 4'hF) lit_cnt++;
    if (bus.an == 4'hD || bus.an == 4'h7) bad_an++;
    c++;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".an"}, 32'(bus.an), 32'h0000_000F);
    check_eq({tag, ".sseg"}, 32'(bus.sseg), 32'h0000_00FF);
    check_eq({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

  initial begin
    bus.dig_0   = 8'hC0;
    bus.dig_1   = 8'hF9;
    bus.dig_2   = 8'hA4;
    bus.dig_3   = 8'hB0;
    bus.en_mask = 4'hF;
    bus.duty    = 4'd15;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    c = 0;

    run(96, "t1");

    run(10, "t4pre");
    bus.dig_0 = 8'h80;
    run(22, "t4hold");
    run(32, "t4new");

    run(13, "t5pre");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t5reset");
    reset = 1'b0;
    c = 0;
    bus.dig_0 = 8'hC0;
    run(64, "t5");

    bus.en_mask = 4'b0101;
    bad_an = 0;
    run(64, "t2");
    check_eq("t2.no_disabled_anode", 32'(bad_an), 32'd0);

    bus.en_mask = 4'hF;
    bus.duty    = 4'd4;
    lit_cnt     = 0;
    run(256, "t3");
    check_eq("t3.lit_count_duty4", 32'(lit_cnt), 32'd32);

    bus.duty = 4'd0;
    lit_cnt  = 0;
    run(64, "t3z");
    check_eq("t3.lit_count_duty0", 32'(lit_cnt), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      bus.dig_0   = 8'($urandom);
      bus.dig_1   = 8'($urandom);
      bus.dig_2   = 8'($urandom);
      bus.dig_3   = 8'($urandom);
      bus.en_mask = 4'($urandom);
      bus.duty    = 4'($urandom);
      step("t6");
      check_eq("t6.an_onehot", 32'(bus.an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
